// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter width, FSM state type and a small
// window-compare helper used by the sync decoder.
package vga_pkg;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_FRONT_PORCH_H = 18;
  localparam int DEF_BACK_PORCH_H  = 50;
  localparam int DEF_FRONT_PORCH_V = 10;
  localparam int DEF_BACK_PORCH_V  = 33;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] pos_t;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } vga_state_e;

  // True when pos lies inside the inclusive window [lo, hi].
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Column/row position tracker. The counters hold the position of the next
// input sample. A load snaps them to (1,0) because the load cycle itself is
// position (0,0); advance steps the column and carries into the row.
module vga_pos_counter
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic advance,
  output pos_t col,
  output pos_t row
);

  localparam pos_t COL_LAST = pos_t'(TOTAL_COLS - 1);
  localparam pos_t ROW_LAST = pos_t'(TOTAL_ROWS - 1);

  // Position update: reset, then frame re-alignment, then normal stepping with wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= pos_t'(1);
      row <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + pos_t'(1);
      end else begin
        col <= col + pos_t'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync_porch.sv
// VGA sync/porch generator. Locks onto the rising edge of the upstream
// active-row flag, then regenerates active-low H/V sync pulses and blanks
// the colour outside the visible region. All outputs are registered one
// cycle after the input sample they describe.
// Optional feature: define VGA_SYNC_PORCH_LOCK_CHECK_EN to add O_Lock_Err,
// a sticky flag raised when a frame start arrives while the counters
// disagree with it (cleared only by RST).
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_H = DEF_FRONT_PORCH_H,
  parameter int BACK_PORCH_H  = DEF_BACK_PORCH_H,
  parameter int FRONT_PORCH_V = DEF_FRONT_PORCH_V,
  parameter int BACK_PORCH_V  = DEF_BACK_PORCH_V
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I_H_Sync,
  input  logic       I_V_Sync,
  input  logic [3:0] I_Red,
  input  logic [3:0] I_Grn,
  input  logic [3:0] I_Blu,
  output logic       O_H_Sync,
  output logic       O_V_Sync,
  output logic [3:0] O_Red,
  output logic [3:0] O_Grn,
  output logic [3:0] O_Blu,
  output logic       O_Active
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
  ,
  output logic       O_Lock_Err
`endif
);

  localparam pos_t ACT_COLS     = pos_t'(ACTIVE_COLS);
  localparam pos_t ACT_ROWS     = pos_t'(ACTIVE_ROWS);
  localparam pos_t H_SYNC_FIRST = pos_t'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam pos_t H_SYNC_LAST  = pos_t'(TOTAL_COLS - BACK_PORCH_H - 1);
  localparam pos_t V_SYNC_FIRST = pos_t'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam pos_t V_SYNC_LAST  = pos_t'(TOTAL_ROWS - BACK_PORCH_V - 1);

  vga_state_e state;
  logic       prev_v;
  logic       frame_start;
  logic       tracking;
  pos_t       col_cnt;
  pos_t       row_cnt;
  pos_t       cur_col;
  pos_t       cur_row;
  logic       pix_active;
  logic       h_low;
  logic       v_low;

  // The column flag carries no information the counters lack; it is only
  // kept so the port list matches the upstream timing generator.
  logic unused_h_sync;
  assign unused_h_sync = I_H_Sync;

  assign frame_start = I_V_Sync && !prev_v;
  assign tracking    = frame_start || (state == RUN);

  // The detection cycle is position (0,0); otherwise the counters already
  // hold the position of the sample on the inputs this cycle.
  assign cur_col = frame_start ? '0 : col_cnt;
  assign cur_row = frame_start ? '0 : row_cnt;

  assign pix_active = (cur_col < ACT_COLS) && (cur_row < ACT_ROWS);
  assign h_low      = in_window(cur_col, H_SYNC_FIRST, H_SYNC_LAST);
  assign v_low      = in_window(cur_row, V_SYNC_FIRST, V_SYNC_LAST);

  vga_pos_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_pos_counter (
    .CLK     (CLK),
    .RST     (RST),
    .load    (frame_start),
    .advance (state == RUN),
    .col     (col_cnt),
    .row     (row_cnt)
  );

  // Lock FSM and frame-edge history; a frame start always (re)enters RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= WAIT_FRAME;
      prev_v <= 1'b1;
    end else begin
      prev_v <= I_V_Sync;
      if (frame_start) begin
        state <= RUN;
      end
    end
  end

  // Registered sync decode and colour blanking for the current sample.
  always_ff @(posedge CLK) begin
    if (RST || !tracking) begin
      O_H_Sync <= 1'b1;
      O_V_Sync <= 1'b1;
      O_Active <= 1'b0;
      O_Red    <= 4'h0;
      O_Grn    <= 4'h0;
      O_Blu    <= 4'h0;
    end else begin
      O_H_Sync <= !h_low;
      O_V_Sync <= !v_low;
      O_Active <= pix_active;
      O_Red    <= pix_active ? I_Red : 4'h0;
      O_Grn    <= pix_active ? I_Grn : 4'h0;
      O_Blu    <= pix_active ? I_Blu : 4'h0;
    end
  end

`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
  logic misalign;
  assign misalign = frame_start && (state == RUN) &&
                    ((col_cnt != '0) || (row_cnt != '0));

  // Sticky record of any frame start that disagreed with the counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      O_Lock_Err <= 1'b0;
    end else if (misalign) begin
      O_Lock_Err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_porch.sv
// Testbench for vga_sync_porch using a reduced frame geometry so several
// frames fit in a short run. Expected outputs come from a frame-index model
// of the upstream raster; DUT sync/active timing is also measured and held
// against hand-computed numbers for this geometry.
// Builds with or without VGA_SYNC_PORCH_LOCK_CHECK_EN.
module tb_vga_sync_porch;

  localparam int TC    = 80;
  localparam int TR    = 30;
  localparam int AC    = 64;
  localparam int AR    = 20;
  localparam int FPH   = 4;
  localparam int BPH   = 6;
  localparam int FPV   = 2;
  localparam int BPV   = 5;
  localparam int FRAME = TC * TR;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       I_H_Sync = 1'b0;
  logic       I_V_Sync = 1'b0;
  logic [3:0] I_Red    = 4'h0;
  logic [3:0] I_Grn    = 4'h0;
  logic [3:0] I_Blu    = 4'h0;
  logic       O_H_Sync;
  logic       O_V_Sync;
  logic [3:0] O_Red;
  logic [3:0] O_Grn;
  logic [3:0] O_Blu;
  logic       O_Active;
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
  logic       O_Lock_Err;
`endif

  always #20 CLK = ~CLK;

  vga_sync_porch #(
    .TOTAL_COLS    (TC),
    .TOTAL_ROWS    (TR),
    .ACTIVE_COLS   (AC),
    .ACTIVE_ROWS   (AR),
    .FRONT_PORCH_H (FPH),
    .BACK_PORCH_H  (BPH),
    .FRONT_PORCH_V (FPV),
    .BACK_PORCH_V  (BPV)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .I_H_Sync (I_H_Sync),
    .I_V_Sync (I_V_Sync),
    .I_Red    (I_Red),
    .I_Grn    (I_Grn),
    .I_Blu    (I_Blu),
    .O_H_Sync (O_H_Sync),
    .O_V_Sync (O_V_Sync),
    .O_Red    (O_Red),
    .O_Grn    (O_Grn),
    .O_Blu    (O_Blu),
    .O_Active (O_Active)
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
    ,
    .O_Lock_Err (O_Lock_Err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: upstream raster position as a linear index within the frame.
  logic       m_seen_rst = 1'b0;
  logic       m_prev_v   = 1'b1;
  logic       m_locked   = 1'b0;
  logic       m_lock_err = 1'b0;
  int         m_next     = 0;
  int         m_pos      = 0;
  int         m_c        = 0;
  int         m_r        = 0;
  logic       e_hs       = 1'b1;
  logic       e_vs       = 1'b1;
  logic       e_act      = 1'b0;
  logic [3:0] e_r        = 4'h0;
  logic [3:0] e_g        = 4'h0;
  logic [3:0] e_b        = 4'h0;

  // Measurements on DUT outputs, in units of monitor cycles.
  int   cyc         = 0;
  int   fs_cyc      = 0;
  logic p_hs        = 1'b1;
  logic p_vs        = 1'b1;
  logic p_act       = 1'b0;
  int   hs_fall     = 0;
  int   hs_prev     = 0;
  int   hs_low_len  = 0;
  int   vs_fall     = 0;
  int   vs_prev     = 0;
  int   vs_low_len  = 0;
  int   act_rise    = 0;
  int   act_len     = 0;

  task automatic model_step();
    if (RST) begin
      m_seen_rst = 1'b1;
      m_prev_v   = 1'b1;
      m_locked   = 1'b0;
      m_lock_err = 1'b0;
      m_next     = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0;
      e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    end else begin
      if (I_V_Sync && !m_prev_v) begin
        if (m_locked && m_next != 0) m_lock_err = 1'b1;
        m_locked = 1'b1;
        m_pos    = 0;
      end else begin
        m_pos = m_next;
      end
      if (m_locked) begin
        m_c   = m_pos % TC;
        m_r   = m_pos / TC;
        e_act = (m_c < AC) && (m_r < AR);
        e_hs  = !((m_c >= AC + FPH) && (m_c <= TC - BPH - 1));
        e_vs  = !((m_r >= AR + FPV) && (m_r <= TR - BPV - 1));
        e_r   = e_act ? I_Red : 4'h0;
        e_g   = e_act ? I_Grn : 4'h0;
        e_b   = e_act ? I_Blu : 4'h0;
        m_next = (m_pos + 1) % FRAME;
      end else begin
        e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0;
        e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
      end
      m_prev_v = I_V_Sync;
    end
  endtask

  task automatic monitor_step();
    if (p_hs && !O_H_Sync) begin hs_prev = hs_fall; hs_fall = cyc; end
    if (!p_hs && O_H_Sync) hs_low_len = cyc - hs_fall;
    if (p_vs && !O_V_Sync) begin vs_prev = vs_fall; vs_fall = cyc; end
    if (!p_vs && O_V_Sync) vs_low_len = cyc - vs_fall;
    if (!p_act && O_Active) act_rise = cyc;
    if (p_act && !O_Active) act_len = cyc - act_rise;
    p_hs  = O_H_Sync;
    p_vs  = O_V_Sync;
    p_act = O_Active;
  endtask

  // Every cycle after the first reset: step the model and compare all outputs.
  initial begin
    logic [15:0] exp_vec;
    logic [15:0] act_vec;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      model_step();
      if (m_seen_rst) begin
        exp_vec = {1'b0, e_hs, e_vs, e_act, e_r, e_g, e_b};
        act_vec = {1'b0, O_H_Sync, O_V_Sync, O_Active, O_Red, O_Grn, O_Blu};
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
        exp_vec[15] = m_lock_err;
        act_vec[15] = O_Lock_Err;
`endif
        check_output($sformatf("outputs_cyc%0d", cyc), 32'(act_vec), 32'(exp_vec));
        monitor_step();
      end
    end
  end

  task automatic apply_stimulus(input int c, input int r, input logic force_v_low);
    @(negedge CLK);
    I_H_Sync = (c < AC);
    I_V_Sync = (r < AR) && !force_v_low;
    I_Red    = 4'hF;
    I_Grn    = 4'(c);
    I_Blu    = 4'(c + r + 1);
  endtask

  task automatic run_span(input int start_idx, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (start_idx + i) % FRAME;
      apply_stimulus(idx % TC, idx / TC, 1'b0);
      if (idx == 0) fs_cyc = cyc + 1;
    end
  endtask

  task automatic wait_output();
    @(posedge CLK);
    #2;
  endtask

  task automatic expect_idle(input string tag);
    check_output({tag, "_hsync"},  32'(O_H_Sync), 32'd1);
    check_output({tag, "_vsync"},  32'(O_V_Sync), 32'd1);
    check_output({tag, "_active"}, 32'(O_Active), 32'd0);
    check_output({tag, "_rgb"},    32'({O_Red, O_Grn, O_Blu}), 32'd0);
  endtask

  // Directed sequence: reset, idle, three locked frames, misalignment, mid-frame reset.
  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    wait_output();
    expect_idle("reset");
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
    check_output("reset_lock_err", 32'(O_Lock_Err), 32'd0);
`endif

    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      RST = 1'b0;
      I_H_Sync = 1'b1;
      I_V_Sync = 1'b0;
      I_Red = 4'hF; I_Grn = 4'hA; I_Blu = 4'h5;
    end
    wait_output();
    expect_idle("no_frame_idle");

    run_span(0, 1);
    wait_output();
    check_output("first_px_active", 32'(O_Active), 32'd1);
    check_output("first_px_red", 32'(O_Red), 32'hF);
    check_output("first_px_latency", 32'(act_rise), 32'(fs_cyc));

    run_span(1, 64);
    wait_output();
    check_output("col64_active", 32'(O_Active), 32'd0);
    check_output("col64_rgb", 32'({O_Red, O_Grn, O_Blu}), 32'd0);

    run_span(65, 2 * TC - 65 + 2);
    check_output("active_run_len", 32'(act_len), 32'd64);
    check_output("hsync_low_len", 32'(hs_low_len), 32'd6);
    check_output("hsync_period", 32'(hs_fall - hs_prev), 32'd80);
    check_output("hsync_start_col", 32'(hs_fall - fs_cyc), 32'(TC + 68));

    run_span(2 * TC + 2, 25 * TC + 2 - (2 * TC + 2));
    check_output("vsync_start_row", 32'(vs_fall - fs_cyc), 32'(22 * TC));
    check_output("vsync_low_len", 32'(vs_low_len), 32'd240);

    run_span(25 * TC + 2, 3 * FRAME + 5 - (25 * TC + 2));
    check_output("vsync_period", 32'(vs_fall - vs_prev), 32'd2400);
    check_output("hsync_period_f3", 32'(hs_fall - hs_prev), 32'd80);
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
    check_output("aligned_lock_err", 32'(O_Lock_Err), 32'd0);
`endif

    run_span(5, 10 * TC - 5);
    apply_stimulus(0, 10, 1'b1);
    run_span(0, 1);
    wait_output();
    check_output("realign_active", 32'(O_Active), 32'd1);
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
    check_output("realign_lock_err", 32'(O_Lock_Err), 32'd1);
`endif
    run_span(1, 2 * TC + 1);
    check_output("realign_hsync_col", 32'(hs_fall - fs_cyc), 32'(TC + 68));

    run_span(2 * TC + 2, 17 * TC + 41 - (2 * TC + 2));
    apply_stimulus(41, 17, 1'b0);
    RST = 1'b1;
    wait_output();
    expect_idle("midframe_reset");
`ifdef VGA_SYNC_PORCH_LOCK_CHECK_EN
    check_output("midframe_reset_lock_err", 32'(O_Lock_Err), 32'd0);
`endif
    apply_stimulus(42, 17, 1'b0);
    RST = 1'b0;
    run_span(17 * TC + 43, 18 * TC + 11 - (17 * TC + 43));
    wait_output();
    expect_idle("no_resume_before_fs");

    run_span(18 * TC + 11, FRAME - (18 * TC + 11));
    run_span(0, 1);
    wait_output();
    check_output("resume_active", 32'(O_Active), 32'd1);
    check_output("resume_red", 32'(O_Red), 32'hF);
    run_span(1, 5);
    wait_output();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_porch.md
VGA_SYNC_PORCH -- requirements
Module: vga_sync_porch

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning pixel clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning visible pixels per line.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-005 SHALL have parameters FRONT_PORCH_H/BACK_PORCH_H/FRONT_PORCH_V/BACK_PORCH_V, defaults 18/50/10/33, meaning porch lengths in pixels/lines.
REQ-006 SHALL have port CLK  in  1  pixel clock (25 MHz); one clock, no other clock domains.
REQ-007 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports I_H_Sync, I_V_Sync  in  1 each  upstream active-region flags (high = active column/row region).
REQ-009 SHALL have ports I_Red, I_Grn, I_Blu  in  4 each  pixel colour aligned with I_H_Sync/I_V_Sync.
REQ-010 SHALL have ports O_H_Sync, O_V_Sync  out  1 each  VGA sync pulses, active low.
REQ-011 SHALL have ports O_Red, O_Grn, O_Blu  out  4 each  blanked colour to DAC.
REQ-012 SHALL have port O_Active  out  1  high when output pixel is in visible region.

Function
REQ-013 SHALL implement FSM with states WAIT_FRAME and RUN.
REQ-014 SHALL detect frame start as I_V_Sync high in current cycle with registered previous I_V_Sync low.
REQ-015 WAIT_FRAME: O_H_Sync=O_V_Sync=1, RGB=0, O_Active=0; on frame start -> RUN.
REQ-016 On frame start (either state), Col_Cnt SHALL load 1 and Row_Cnt load 0 (counters track position of next input sample; detection cycle is position (0,0)).
REQ-017 In RUN, Col_Cnt SHALL increment each cycle, wrapping TOTAL_COLS-1 -> 0; Row_Cnt SHALL increment on that wrap, wrapping TOTAL_ROWS-1 -> 0.
REQ-018 Counters SHALL be 10 bits; no value outside 0..TOTAL-1 ever reached.
REQ-019 O_H_Sync SHALL be 0 iff column in [ACTIVE_COLS+FRONT_PORCH_H, TOTAL_COLS-BACK_PORCH_H-1] (defaults 658..749), else 1.
REQ-020 O_V_Sync SHALL be 0 iff row in [ACTIVE_ROWS+FRONT_PORCH_V, TOTAL_ROWS-BACK_PORCH_V-1] (defaults 490..491), else 1.
REQ-021 O_Active SHALL be 1 iff column < ACTIVE_COLS and row < ACTIVE_ROWS.
REQ-022 O_Red/Grn/Blu SHALL equal the input colour when O_Active=1, else 0.
REQ-023 All outputs SHALL be registered with latency exactly 1 cycle from the input sample at the same position.
REQ-024 Frame start in RUN at counter position other than (0,0) SHALL re-align counters per REQ-016 without leaving RUN.

Reset
REQ-025 RST SHALL force state WAIT_FRAME, counters 0, previous-V register 1, O_H_Sync=O_V_Sync=1, RGB=0, O_Active=0 on next CLK edge.
REQ-026 RST asserted mid-frame SHALL take priority over all counting and frame-start detection.

Configuration
REQ-027 With VGA_SYNC_PORCH_LOCK_CHECK_EN defined, module SHALL add output O_Lock_Err (1 bit, reset 0), set sticky on REQ-024 misalignment, cleared only by RST.
REQ-028 Without VGA_SYNC_PORCH_LOCK_CHECK_EN, port O_Lock_Err and its logic SHALL be absent; REQ-024 behaviour unchanged.

Structure
REQ-029 Shared package vga_pkg SHALL hold default timing constants (800/525/640/480, porches) and FSM state enum.
REQ-030 Counters SHALL be one sub-module vga_pos_counter (col/row, load, wrap); FSM, sync decode and pixel gating in top.

Verification
REQ-031 Reset then no V edge for 1000 cycles -> syncs stay 1, RGB 0, O_Active 0.
REQ-032 Drive upstream timing, I_Red=4'hF: O_Active high for 640 cycles per line, first output cycle after frame start +1; col 640 -> RGB 0.
REQ-033 Measure O_H_Sync low width = 92 cycles starting output col 658; O_V_Sync low for 2 lines starting row 490.
REQ-034 Inject extra V rising edge at row 100 -> counters realign to (0,0); O_Lock_Err=1 when macro defined, port absent otherwise.
REQ-035 Assert RST at row 300, col 400 for 1 cycle -> all outputs reset values next cycle; resume only after next frame start.
REQ-036 Run 3 frames -> O_V_Sync period 420000 cycles, O_H_Sync period 800 cycles.
